// File: rtl/pio_pkg.sv
// Shared definitions for the pulse-capable output port.
//   - Avalon word addresses of the register map
//   - STATUS register bit positions
//   - pulse timer state encoding
package pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLR    = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_LEN    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;

    typedef enum logic {S_IDLE, S_PULSE} state_t;

endpackage

// File: rtl/pio_pulse_out_if.sv
// Avalon-MM slave bus bundle for pio_pulse_out.
//   address    3-bit word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit combinational read data (zero wait states)
interface pio_pulse_out_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_pulse_timer.sv
// Pulse timer: loadable down-counter plus IDLE/PULSE state machine.
//   clk, reset  system clock, synchronous active-high reset
//   start       begin a pulse (only honoured in IDLE)
//   len         requested pulse length in cycles (0 treated as 1)
//   abort       terminate an active pulse on this edge
//   busy        registered, high for every cycle of the pulse
//   done        registered one-cycle strobe when a pulse expires naturally
module pio_pulse_timer
    import pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // cnt holds the number of busy cycles still to follow the current one,
    // so loading len-1 gives exactly len busy cycles; len==0 behaves as 1.
    function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] l);
        return (l == '0) ? '0 : l - CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_PULSE;
                        busy  <= 1'b1;
                        cnt   <= load_value(len);
                    end
                end
                S_PULSE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pio_pulse_out.sv
// Avalon-MM output port with atomic SET/CLEAR and a hardware-timed pulse mode.
//   clk, reset  system clock, synchronous active-high reset
//   bus         Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port    pin drive = data ^ (busy ? pulse_mask : 0)
//   busy        high while a pulse is in progress
module pio_pulse_out
    import pio_pkg::*;
#(
    parameter int               WIDTH             = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter int               CNT_W             = 16,
    parameter int               DEFAULT_PULSE_LEN = 50000
) (
    input  logic             clk,
    input  logic             reset,
    pio_pulse_out_if.slave   bus,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pulse_mask;
    logic [CNT_W-1:0] pulse_len;
    logic             err;
    logic             done;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             wr_pulse;
    logic             wr_status;
    logic             start;
    logic             abort;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign wr_pulse  = wr && (bus.address == ADDR_PULSE);
    assign wr_status = wr && (bus.address == ADDR_STATUS);
    assign start     = wr_pulse && !busy && (wd != '0);
    assign abort     = wr_status && bus.writedata[ST_BUSY] && busy;
    assign unused_wd = ^bus.writedata;

    pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (pulse_len),
        .abort (abort),
        .busy  (busy),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= RESET_VALUE;
            pulse_len  <= CNT_W'(DEFAULT_PULSE_LEN);
            pulse_mask <= '0;
            err        <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.address)
                    ADDR_DATA: data      <= wd;
                    ADDR_SET:  data      <= data | wd;
                    ADDR_CLR:  data      <= data & ~wd;
                    ADDR_LEN:  pulse_len <= bus.writedata[CNT_W-1:0];
                    default:   ;
                endcase
            end

            if (start)
                pulse_mask <= wd;
            else if (done || abort)
                pulse_mask <= '0;

            // A second PULSE request cannot be queued; flag it for software.
            if (wr_pulse && busy)
                err <= 1'b1;
            else if (wr_status && bus.writedata[ST_ERR])
                err <= 1'b0;
        end
    end

    // Gating with busy makes the pin and the PULSE readback drop on the
    // same edge the timer leaves PULSE.
    assign out_port = data ^ (busy ? pulse_mask : '0);

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata[WIDTH-1:0] = data;
            ADDR_PULSE:  bus.readdata[WIDTH-1:0] = busy ? pulse_mask : '0;
            ADDR_LEN:    bus.readdata[CNT_W-1:0] = pulse_len;
            ADDR_STATUS: begin
                bus.readdata[ST_BUSY] = busy;
                bus.readdata[ST_ERR]  = err;
            end
            default:     bus.readdata = '0;
        endcase
    end

endmodule
